// File: rtl/uart_xmit_arbiter.sv
// uart_xmit_arbiter: shares one UART transmitter among NUM_REQ byte requesters.
// Round-robin arbitration. Each frame is sequenced as: latch byte, pulse Start,
// wait for Busy to rise (with timeout), then wait for Busy to fall.
// Optional feature: define UART_ARB_LOCK_EN to let a requester hold the grant
// across bytes through ReqLock. Without it, ReqLock is ignored.
module uart_xmit_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned ID_W         = 2,
   parameter int unsigned BUSY_TIMEOUT = 15
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [NUM_REQ-1:0]   ReqValid,
   input  logic [8*NUM_REQ-1:0] ReqData,
   input  logic [NUM_REQ-1:0]   ReqLock,
   output logic [NUM_REQ-1:0]   ReqReady,
   output logic [7:0]           XmitData,
   output logic                 XmitStart,
   input  logic                 XmitBusy,
   output logic [ID_W-1:0]      GrantId,
   output logic                 Active,
   output logic                 TimeoutErr
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_RISE = 2'd2,
      WAIT_FALL = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic [7:0]           data_q, data_d;
   logic                 start_q, start_d;
   logic [ID_W-1:0]      grant_q, grant_d;
   logic                 active_q, active_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [NUM_REQ-1:0]   cand_c;
   logic                 win_found_c;
   logic [IDX_W-1:0]     win_id_c;
   logic [7:0]           win_data_c;
   int unsigned          scan_idx_c;

`ifdef UART_ARB_LOCK_EN
   logic                 lock_vld_q, lock_vld_d;
   logic [IDX_W-1:0]     lock_own_q, lock_own_d;
   logic                 lock_hold_c;

   // Candidate set: only the lock owner may compete while it holds ReqLock
   always_comb begin
      lock_hold_c = lock_vld_q & ReqLock[lock_own_q];
      cand_c      = ReqValid;
      if (lock_hold_c) begin
         cand_c = ReqValid & (NUM_REQ'(1) << lock_own_q);
      end
   end
`else
   logic                 lock_unused;

   assign lock_unused = ^ReqLock;

   // Candidate set: every valid requester competes
   always_comb begin
      cand_c = ReqValid;
   end
`endif

   // Round-robin scan starting just after the last granted requester
   always_comb begin
      win_found_c = 1'b0;
      win_id_c    = '0;
      win_data_c  = '0;
      scan_idx_c  = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         scan_idx_c = (32'(grant_q) + k) % NUM_REQ;
         if (!win_found_c && cand_c[IDX_W'(scan_idx_c)]) begin
            win_found_c = 1'b1;
            win_id_c    = IDX_W'(scan_idx_c);
            win_data_c  = ReqData[8*scan_idx_c +: 8];
         end
      end
   end

   // Next-state and registered-output logic for the frame sequencer
   always_comb begin
      state_d  = state_q;
      ready_d  = '0;
      data_d   = data_q;
      start_d  = 1'b0;
      grant_d  = grant_q;
      active_d = active_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
`ifdef UART_ARB_LOCK_EN
      lock_vld_d = lock_vld_q;
      lock_own_d = lock_own_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef UART_ARB_LOCK_EN
            if (lock_vld_q && !ReqLock[lock_own_q]) begin
               lock_vld_d = 1'b0;
            end
`endif
            if (win_found_c && !XmitBusy) begin
               ready_d  = NUM_REQ'(1) << win_id_c;
               data_d   = win_data_c;
               start_d  = 1'b1;
               grant_d  = ID_W'(win_id_c);
               active_d = 1'b1;
               state_d  = START;
`ifdef UART_ARB_LOCK_EN
               lock_vld_d = ReqLock[win_id_c];
               lock_own_d = win_id_c;
`endif
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (XmitBusy) begin
               state_d = WAIT_FALL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(BUSY_TIMEOUT)) begin
                  err_d    = 1'b1;
                  active_d = 1'b0;
                  state_d  = IDLE;
               end
            end
         end
         WAIT_FALL: begin
            if (!XmitBusy) begin
               active_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         ready_q  <= '0;
         data_q   <= '0;
         start_q  <= 1'b0;
         grant_q  <= ID_W'(NUM_REQ - 1);
         active_q <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         data_q   <= data_d;
         start_q  <= start_d;
         grant_q  <= grant_d;
         active_q <= active_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef UART_ARB_LOCK_EN
   // Lock owner register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lock_vld_q <= 1'b0;
         lock_own_q <= '0;
      end else begin
         lock_vld_q <= lock_vld_d;
         lock_own_q <= lock_own_d;
      end
   end
`endif

   assign ReqReady   = ready_q;
   assign XmitData   = data_q;
   assign XmitStart  = start_q;
   assign GrantId    = grant_q;
   assign Active     = active_q;
   assign TimeoutErr = err_q;

endmodule
